fpga_link_rx: RTL

- Receive end of the 17-bit inter-FPGA link; the transmit end drives data_TO_fpgaN pins from router outputs.
- Samples the plesiochronous link_in bus, synchronizes it and debounces it by stability filtering.
- Extracts one flit per return-to-zero valid pulse and buffers flits in a small FIFO.
- Presents flits to the local router port with a valid/ready handshake.

---
 rtl/link_pkg.sv | 13 +
 rtl/link_rx_fifo.sv | 73 +++++++
 rtl/fpga_link_rx.sv | 100 ++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared constants and state encoding for the inter-FPGA link receiver.
package link_pkg;

  localparam int LINK_W    = 17;
  localparam int VALID_BIT = 16;
  localparam int PAYLOAD_W = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } rx_state_e;

endpackage

// File: rtl/link_rx_fifo.sv
// Synchronous flit FIFO with a registered head word; a push that finds the
// FIFO full is refused unless a pop frees a slot in the same cycle.
module link_rx_fifo
  import link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PAYLOAD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop_req,
  output logic [W-1:0]               head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [LVL_W-1:0] level_q;
  logic [W-1:0]     head_q;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign do_pop   = pop_req && !empty;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign rd_ptr_n = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  // NOTE: the storage array has no reset; only pointers, level and head are
  // cleared, so synthesis can map it to plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_n;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      // Head tracks the slot that will be at the read pointer after this
      // edge, taking the incoming word when it lands exactly there.
      head_q <= (do_push && (wr_ptr_q == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
    end
  end

  assign head  = head_q;
  assign valid = !empty;
  assign level = level_q;

endmodule

// File: rtl/fpga_link_rx.sv
// Receive end of the 17-bit inter-FPGA link: synchronize, stability-filter,
// extract one flit per valid pulse and hand it to the router through a FIFO.
module fpga_link_rx
  import link_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LINK_W-1:0]               link_in,
  output logic [PAYLOAD_W-1:0]            flit_out,
  output logic                            flit_valid,
  input  logic                            flit_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [LINK_W-1:0]  sync_q [SYNC_STAGES];
  logic [SYNC_STAGES:0] fill_q;
  logic [LINK_W-1:0]  prev_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               match;
  logic               stable;
  rx_state_e          state_q;
  rx_state_e          state_d;
  logic               push;
  logic               drop;

  // fill_q marks which stages hold real samples since reset release, so the
  // cleared registers never masquerade as a stable low valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q[0] <= link_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!match)              cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match  = fill_q[SYNC_STAGES] && (sync_q[SYNC_STAGES-1] == prev_q);
  // prev_q is the word the counter vouches for: it has held for cnt_q+1 samples.
  assign stable = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_LOW;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stable && prev_q[VALID_BIT]) begin
          push    = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (stable && !prev_q[VALID_BIT]) state_d = IDLE;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  link_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAYLOAD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (prev_q[PAYLOAD_W-1:0]),
    .pop_req (flit_ready),
    .head    (flit_out),
    .valid   (flit_valid),
    .level   (fifo_level),
    .drop    (drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

endmodule
